// File: rtl/riscv_pkg.sv
// Shared RV32I front-end types: canonical NOP, fetch FSM states and fetch-buffer entry layout.
package riscv_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_entry_t;

endpackage

// File: rtl/if_fetch_buf.sv
// Fetch buffer: power-of-two FIFO of {pc, instr} entries with flush; the head is visible combinationally.
module if_fetch_buf
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  if_entry_t     push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output if_entry_t     head_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    if_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone says which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem fetch FSM, fetch buffer and EX redirect.
// Optional build macro IF_MISALIGN_TRAP_EN adds if_misalign_o and traps misaligned redirect targets.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        br_sel_i,
    input  logic [31:0] br_target_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
`ifdef IF_MISALIGN_TRAP_EN
    output logic        if_misalign_o,
`endif
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

    if_state_e     state_q, state_d;
    logic [31:0]   pc_q;
    logic [31:0]   req_pc_q;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] buf_count;
    logic          buf_full;
    logic          buf_push;
    logic          buf_pop;
    logic          head_valid;
    logic          fetch_hold;
    logic          fetch_fire;
    if_entry_t     buf_head;
    if_entry_t     push_entry;

`ifdef IF_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       misalign_q <= 1'b0;
        else if (br_sel_i) misalign_q <= |br_target_i[1:0];
    end

    assign fetch_hold  = misalign_q;
    assign redirect_pc = br_target_i;
`else
    assign fetch_hold  = 1'b0;
    assign redirect_pc = br_target_i & ~32'h3;
`endif

    assign head_valid = (buf_count != '0);
    assign buf_pop    = head_valid && !stall_i && !br_sel_i;
    assign fetch_fire = (state_q == IDLE) && imem_req_o && imem_gnt_i;
    assign push_entry = '{pc: req_pc_q, instr: imem_rdata_i};

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        imem_req_o = 1'b0;
        buf_push   = 1'b0;
        case (state_q)
            IDLE: begin
                // rst_ni gating keeps the request low while reset is held, not only after it.
                imem_req_o = rst_ni && !br_sel_i && !fetch_hold && (!buf_full || buf_pop);
                if (br_sel_i) begin
                    if (imem_gnt_i) state_d = DROP;
                end else if (imem_req_o && imem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    buf_push = !br_sel_i;
                    state_d  = IDLE;
                end else if (br_sel_i) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (br_sel_i) begin
                pc_q <= redirect_pc;
            end else if (fetch_fire) begin
                req_pc_q <= pc_q;
                pc_q     <= pc_q + 32'd4;
            end
        end
    end

    assign imem_addr_o = pc_q;

    if_fetch_buf #(
        .DEPTH (BUF_DEPTH),
        .CW    (CW)
    ) u_fetch_buf (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (buf_push),
        .push_data_i (push_entry),
        .pop_i       (buf_pop),
        .flush_i     (br_sel_i),
        .count_o     (buf_count),
        .full_o      (buf_full),
        .head_o      (buf_head)
    );

    always_comb begin
        if_valid_o = head_valid;
        if_instr_o = head_valid ? buf_head.instr : RV_NOP;
        if_pc_o    = head_valid ? buf_head.pc : 32'h0;
`ifdef IF_MISALIGN_TRAP_EN
        // A trapped target is presented as a NOP at that PC until the next redirect.
        if (misalign_q) begin
            if_valid_o = 1'b1;
            if_instr_o = RV_NOP;
            if_pc_o    = pc_q;
        end
        if_misalign_o = misalign_q;
`endif
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: streaming fetch, stall/backpressure, redirects, PC wrap, mid-transaction reset.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        br_sel_i;
    logic [31:0] br_target_i;
    logic        stall_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
`ifdef IF_MISALIGN_TRAP_EN
    logic        if_misalign_o;
`endif
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;

    int          vectors     = 0;
    int          miscompares = 0;
    logic        auto_mem    = 1'b0;
    logic        pend        = 1'b0;
    logic [31:0] pend_addr   = 32'h0;

    if_stage dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .br_sel_i      (br_sel_i),
        .br_target_i   (br_target_i),
        .stall_i       (stall_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
`ifdef IF_MISALIGN_TRAP_EN
        .if_misalign_o (if_misalign_o),
`endif
        .if_valid_o    (if_valid_o),
        .if_instr_o    (if_instr_o),
        .if_pc_o       (if_pc_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return addr ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; with auto_mem the bench grants every request and answers one cycle later.
    task automatic tick();
        #1;
        if (auto_mem) begin
            pend      = imem_req_o && imem_gnt_i;
            pend_addr = imem_addr_o;
        end
        @(posedge clk_i);
        #1;
        if (auto_mem) begin
            imem_gnt_i    = 1'b1;
            imem_rvalid_i = pend;
            imem_rdata_i  = pend ? instr_of(pend_addr) : 32'hDEAD_BEEF;
        end
        br_sel_i = 1'b0;
        #1;
    endtask

    task automatic reset_dut();
        rst_ni        = 1'b0;
        br_sel_i      = 1'b0;
        br_target_i   = 32'h0;
        stall_i       = 1'b0;
        imem_gnt_i    = auto_mem;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        pend          = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        #1;
    endtask

    initial begin
        // Reset values while reset is held.
        rst_ni        = 1'b0;
        br_sel_i      = 1'b0;
        br_target_i   = 32'h0;
        stall_i       = 1'b0;
        imem_gnt_i    = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        #3;
        check("rst_req",   {31'b0, imem_req_o}, 32'd0);
        check("rst_valid", {31'b0, if_valid_o}, 32'd0);
        check("rst_instr", if_instr_o, NOP);
        check("rst_pc",    if_pc_o, 32'h0);

        // Streaming fetch: addresses 0,4,8 issued and delivered in order.
        auto_mem = 1'b1;
        reset_dut();
        check("t1_c0_req",  {31'b0, imem_req_o}, 32'd1);
        check("t1_c0_addr", imem_addr_o, 32'h0);
        tick();
        check("t1_c1_req",  {31'b0, imem_req_o}, 32'd0);
        check("t1_c1_vld",  {31'b0, if_valid_o}, 32'd0);
        tick();
        check("t1_c2_vld",  {31'b0, if_valid_o}, 32'd1);
        check("t1_c2_pc",   if_pc_o, 32'h0);
        check("t1_c2_ins",  if_instr_o, instr_of(32'h0));
        check("t1_c2_addr", imem_addr_o, 32'h4);
        tick();
        check("t1_c3_vld",  {31'b0, if_valid_o}, 32'd0);
        tick();
        check("t1_c4_pc",   if_pc_o, 32'h4);
        check("t1_c4_addr", imem_addr_o, 32'h8);
        tick();
        tick();
        check("t1_c6_pc",   if_pc_o, 32'h8);
        check("t1_c6_ins",  if_instr_o, instr_of(32'h8));

        // Stall for six cycles: buffer fills to two, requests stop, then drains in order.
        reset_dut();
        stall_i = 1'b1;
        tick();
        tick();
        check("t2_c2_pc",   if_pc_o, 32'h0);
        check("t2_c2_addr", imem_addr_o, 32'h4);
        check("t2_c2_req",  {31'b0, imem_req_o}, 32'd1);
        tick();
        tick();
        check("t2_c4_req",  {31'b0, imem_req_o}, 32'd0);
        check("t2_c4_pc",   if_pc_o, 32'h0);
        tick();
        check("t2_c5_req",  {31'b0, imem_req_o}, 32'd0);
        tick();
        stall_i = 1'b0;
        #1;
        check("t2_c6_req",  {31'b0, imem_req_o}, 32'd1);
        check("t2_c6_addr", imem_addr_o, 32'h8);
        check("t2_c6_pc",   if_pc_o, 32'h0);
        tick();
        check("t2_c7_pc",   if_pc_o, 32'h4);
        check("t2_c7_ins",  if_instr_o, instr_of(32'h4));
        tick();
        check("t2_c8_pc",   if_pc_o, 32'h8);
        check("t2_c8_addr", imem_addr_o, 32'hC);

        // Redirect while waiting: the old response is dropped, fetch restarts at 0x100.
        auto_mem = 1'b0;
        reset_dut();
        imem_gnt_i = 1'b1;
        #1;
        check("t3_c0_addr", imem_addr_o, 32'h0);
        tick();
        imem_gnt_i  = 1'b0;
        br_sel_i    = 1'b1;
        br_target_i = 32'h100;
        #1;
        check("t3_c1_req",  {31'b0, imem_req_o}, 32'd0);
        tick();
        check("t3_c2_req",  {31'b0, imem_req_o}, 32'd0);
        check("t3_c2_vld",  {31'b0, if_valid_o}, 32'd0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBAD0_0001;
        tick();
        imem_rvalid_i = 1'b0;
        imem_gnt_i    = 1'b1;
        #1;
        check("t3_c3_vld",  {31'b0, if_valid_o}, 32'd0);
        check("t3_c3_req",  {31'b0, imem_req_o}, 32'd1);
        check("t3_c3_addr", imem_addr_o, 32'h100);
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = instr_of(32'h100);
        tick();
        imem_rvalid_i = 1'b0;
        #1;
        check("t3_c5_vld",  {31'b0, if_valid_o}, 32'd1);
        check("t3_c5_pc",   if_pc_o, 32'h100);
        check("t3_c5_ins",  if_instr_o, instr_of(32'h100));

        // Redirect with gnt and rvalid in the same cycle, under stall, with a buffered entry.
        reset_dut();
        stall_i    = 1'b1;
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = instr_of(32'h0);
        tick();
        imem_rvalid_i = 1'b0;
        #1;
        check("t4_c2_pc",   if_pc_o, 32'h0);
        br_sel_i      = 1'b1;
        br_target_i   = 32'h200;
        imem_gnt_i    = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBAD0_0002;
        #1;
        check("t4_c2_req",  {31'b0, imem_req_o}, 32'd0);
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBAD0_0003;
        #1;
        check("t4_c3_vld",  {31'b0, if_valid_o}, 32'd0);
        check("t4_c3_ins",  if_instr_o, NOP);
        check("t4_c3_req",  {31'b0, imem_req_o}, 32'd0);
        tick();
        imem_rvalid_i = 1'b0;
        #1;
        check("t4_c4_vld",  {31'b0, if_valid_o}, 32'd0);
        check("t4_c4_addr", imem_addr_o, 32'h200);
        check("t4_c4_req",  {31'b0, imem_req_o}, 32'd1);
        br_sel_i    = 1'b1;
        br_target_i = 32'h300;
        #1;
        check("t4_c4_breq", {31'b0, imem_req_o}, 32'd0);
        tick();
        check("t4_c5_req",  {31'b0, imem_req_o}, 32'd1);
        check("t4_c5_addr", imem_addr_o, 32'h300);

        // PC wrap from 0xFFFF_FFFC to 0.
        br_sel_i    = 1'b1;
        br_target_i = 32'hFFFF_FFFC;
        tick();
        check("t5_addr_hi", imem_addr_o, 32'hFFFF_FFFC);
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = instr_of(32'hFFFF_FFFC);
        tick();
        imem_rvalid_i = 1'b0;
        #1;
        check("t5_pc",      if_pc_o, 32'hFFFF_FFFC);
        check("t5_ins",     if_instr_o, instr_of(32'hFFFF_FFFC));
        check("t5_wrap",    imem_addr_o, 32'h0);
        check("t5_req",     {31'b0, imem_req_o}, 32'd1);

        // Asynchronous reset mid-transaction, then a late rvalid in IDLE is ignored.
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("t7_vld",     {31'b0, if_valid_o}, 32'd0);
        check("t7_req",     {31'b0, imem_req_o}, 32'd0);
        check("t7_pc",      if_pc_o, 32'h0);
        tick();
        rst_ni        = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hBAD0_0004;
        tick();
        imem_rvalid_i = 1'b0;
        #1;
        check("t7_late",    {31'b0, if_valid_o}, 32'd0);
        check("t7_addr",    imem_addr_o, 32'h0);

        // Misaligned redirect target.
        reset_dut();
        br_sel_i    = 1'b1;
        br_target_i = 32'h102;
        tick();
`ifdef IF_MISALIGN_TRAP_EN
        check("t6_mis",     {31'b0, if_misalign_o}, 32'd1);
        check("t6_vld",     {31'b0, if_valid_o}, 32'd1);
        check("t6_pc",      if_pc_o, 32'h102);
        check("t6_ins",     if_instr_o, NOP);
        check("t6_req",     {31'b0, imem_req_o}, 32'd0);
        tick();
        check("t6_hold",    {31'b0, if_misalign_o}, 32'd1);
        br_sel_i    = 1'b1;
        br_target_i = 32'h100;
        tick();
        check("t6_clr",     {31'b0, if_misalign_o}, 32'd0);
        check("t6_addr",    imem_addr_o, 32'h100);
        check("t6_req2",    {31'b0, imem_req_o}, 32'd1);
`else
        check("t6_req",     {31'b0, imem_req_o}, 32'd1);
        check("t6_addr",    imem_addr_o, 32'h100);
        check("t6_vld",     {31'b0, if_valid_o}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
